// File: rtl/bus_pkg.sv
// Shared constants and types for the core bus request/grant slave.
// Address bit GPIO_FLAG_BIT selects the GPIO window instead of RAM.
package bus_pkg;

    localparam int unsigned ADDR_W        = 9;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned GPIO_FLAG_BIT = 8;

    localparam logic GPIO_OUT_OFS = 1'b0;
    localparam logic GPIO_IN_OFS  = 1'b1;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        GRANT,
        RECOVER
    } bus_state_t;

    function automatic logic is_gpio(input logic [ADDR_W-1:0] a);
        return a[GPIO_FLAG_BIT];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins, with wrap.
// The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] winner_idx,
    output logic          valid
);

    int unsigned k;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        k          = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (32'(ptr) + i) % N;
            if (!valid && req[k]) begin
                valid      = 1'b1;
                winner[k]  = 1'b1;
                winner_idx = IW'(k);
            end
        end
    end

endmodule

// File: rtl/bus_responder.sv
// Slave end of the core bus: round-robin arbitration, one byte access per
// four cycles into internal RAM or the GPIO window, one-cycle grant pulse.
module bus_responder
    import bus_pkg::*;
#(
    parameter int unsigned N_PORTS   = 2,
    parameter int unsigned RAM_DEPTH = 256,
    parameter int unsigned ADDR_W    = bus_pkg::ADDR_W,
    parameter int unsigned DATA_W    = bus_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_PORTS-1:0]        req,
    input  logic [N_PORTS-1:0]        rw,
    input  logic [N_PORTS*ADDR_W-1:0] addr,
    input  logic [N_PORTS*DATA_W-1:0] wdata,
    output logic [N_PORTS-1:0]        grant,
    output logic [DATA_W-1:0]         rdata,
    input  logic [7:0]                gpio_in,
    output logic [7:0]                gpio_out,
    output logic                      busy
);

    localparam int unsigned IW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    bus_state_t        state;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     cur_idx;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_rw;
    logic [DATA_W-1:0] cur_wdata;

    logic [ADDR_W-1:0] port_addr  [N_PORTS];
    logic [DATA_W-1:0] port_wdata [N_PORTS];

    logic [N_PORTS-1:0] arb_winner;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;

    logic [DATA_W-1:0] mem [RAM_DEPTH];
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic              gpio_out_we;
    logic [DATA_W-1:0] access_data;
    logic [IW-1:0]     next_ptr;

    always_comb begin
        for (int k = 0; k < int'(N_PORTS); k++) begin
            port_addr[k]  = addr[k*ADDR_W +: ADDR_W];
            port_wdata[k] = wdata[k*DATA_W +: DATA_W];
        end
    end

    rr_arbiter #(
        .N (N_PORTS)
    ) u_arb (
        .req        (req),
        .ptr        (rr_ptr),
        .winner     (arb_winner),
        .winner_idx (arb_idx),
        .valid      (arb_valid)
    );

    assign ram_idx = cur_addr[RAM_AW-1:0];

    // Reset in the ACCESS cycle suppresses the commit, so an interrupted write never lands.
    assign ram_we = (state == ACCESS) && !reset && (cur_rw == RW_WRITE) && !is_gpio(cur_addr);

    assign gpio_out_we = (cur_rw == RW_WRITE) && is_gpio(cur_addr)
                         && (cur_addr[0] == GPIO_OUT_OFS);

    assign next_ptr = (cur_idx == IW'(N_PORTS - 1)) ? '0 : cur_idx + 1'b1;

    // Writes echo their data; reads pick RAM, gpio_out or gpio_in.
    always_comb begin
        if (cur_rw == RW_WRITE) begin
            access_data = cur_wdata;
        end else if (!is_gpio(cur_addr)) begin
            access_data = mem[ram_idx];
        end else if (cur_addr[0] == GPIO_IN_OFS) begin
            access_data = DATA_W'(gpio_in);
        end else begin
            access_data = DATA_W'(gpio_out);
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= cur_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            rdata     <= '0;
            gpio_out  <= '0;
            cur_idx   <= '0;
            cur_addr  <= '0;
            cur_rw    <= RW_READ;
            cur_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        cur_idx   <= arb_idx;
                        cur_addr  <= port_addr[arb_idx];
                        cur_rw    <= rw[arb_idx];
                        cur_wdata <= port_wdata[arb_idx];
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata <= access_data;
                    grant <= N_PORTS'(1) << cur_idx;
                    if (gpio_out_we) begin
                        gpio_out <= 8'(cur_wdata);
                    end
                    state <= GRANT;
                end
                GRANT: begin
                    grant  <= '0;
                    rr_ptr <= next_ptr;
                    state  <= RECOVER;
                end
                RECOVER: begin
                    // Requester's stale req is still visible here; deliberately not sampled.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: vector table of single transactions
// plus hand sequences for arbitration, stale req, reset and dropped req.
module tb_bus_responder;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  rw;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  grant;
    logic [7:0]  rdata;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         port;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        int         port;
        logic       rw;
        logic [8:0] a;
        logic [7:0] d;
        logic [7:0] gin;
        logic [7:0] exp_rd;
        logic [7:0] exp_gpio;
    } vec_t;

    vec_t vecs[10];

    bus_responder #(
        .N_PORTS   (2),
        .RAM_DEPTH (256),
        .ADDR_W    (9),
        .DATA_W    (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .rw       (rw),
        .addr     (addr),
        .wdata    (wdata),
        .grant    (grant),
        .rdata    (rdata),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every grant pulse must match the oldest expected transaction.
    always @(negedge clk) begin
        if (!reset && grant != 2'b00) begin
            chk("grant_onehot", 32'($onehot(grant)), 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", 32'(grant), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("grant_port", 32'(grant), 32'(2'b01 << e.port));
                chk("grant_rdata", 32'(rdata), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic [8:0] a, input logic [7:0] d);
        rw[p]            = r;
        addr[p*9 +: 9]   = a;
        wdata[p*8 +: 8]  = d;
    endtask

    task automatic do_txn(input int p, input logic r, input logic [8:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd);
        int lat;
        bit got;
        set_port(p, r, a, d);
        req[p] = 1'b1;
        exp_q.push_back('{p, exp_rd});
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            tick();
            lat++;
            got = grant[p];
        end
        chk("grant_latency", 32'(lat), 32'd2);
        req[p] = 1'b0;
        tick();
        chk("grant_width", 32'(grant), 32'd0);
        chk("busy_recover", 32'(busy), 32'd1);
        tick();
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int times[4];
        int n;
        int cyc;
        bit got;

        vecs[0] = '{0, 1'b1, 9'h010, 8'hA5, 8'h00, 8'hA5, 8'h00};
        vecs[1] = '{0, 1'b0, 9'h010, 8'h00, 8'h00, 8'hA5, 8'h00};
        vecs[2] = '{0, 1'b1, 9'h100, 8'h3C, 8'h00, 8'h3C, 8'h3C};
        vecs[3] = '{0, 1'b0, 9'h101, 8'h00, 8'h5A, 8'h5A, 8'h3C};
        vecs[4] = '{0, 1'b1, 9'h101, 8'hFF, 8'h5A, 8'hFF, 8'h3C};
        vecs[5] = '{0, 1'b0, 9'h100, 8'h00, 8'h5A, 8'h3C, 8'h3C};
        vecs[6] = '{1, 1'b1, 9'h0FF, 8'h77, 8'h00, 8'h77, 8'h3C};
        vecs[7] = '{1, 1'b0, 9'h1FE, 8'h00, 8'h00, 8'h3C, 8'h3C};
        vecs[8] = '{0, 1'b0, 9'h0FF, 8'h00, 8'h00, 8'h77, 8'h3C};
        vecs[9] = '{1, 1'b0, 9'h010, 8'h00, 8'hC3, 8'hA5, 8'h3C};

        reset   = 1'b1;
        req     = '0;
        rw      = '0;
        addr    = '0;
        wdata   = '0;
        gpio_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_gpio_out", 32'(gpio_out), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            gpio_in = vecs[i].gin;
            do_txn(vecs[i].port, vecs[i].rw, vecs[i].a, vecs[i].d, vecs[i].exp_rd);
            chk("vec_gpio_out", 32'(gpio_out), 32'(vecs[i].exp_gpio));
        end

        // Both ports hold req: grants alternate 0,1,0,1 four cycles apart.
        set_port(0, 1'b0, 9'h010, 8'h00);
        set_port(1, 1'b0, 9'h0FF, 8'h00);
        exp_q.push_back('{0, 8'hA5});
        exp_q.push_back('{1, 8'h77});
        exp_q.push_back('{0, 8'hA5});
        exp_q.push_back('{1, 8'h77});
        req = 2'b11;
        n   = 0;
        cyc = 0;
        while (n < 4 && cyc < 30) begin
            tick();
            cyc++;
            if (grant != 2'b00) begin
                times[n] = cyc;
                n++;
            end
        end
        req = 2'b00;
        chk("rr_grant_count", 32'(n), 32'd4);
        chk("rr_first_latency", 32'(times[0]), 32'd2);
        for (int i = 1; i < 4; i++) begin
            chk("rr_spacing", 32'(times[i] - times[i-1]), 32'd4);
        end
        repeat (2) tick();

        // Port 0 keeps a stale req through RECOVER and IDLE; port 1 joins in RECOVER.
        set_port(0, 1'b0, 9'h010, 8'h00);
        exp_q.push_back('{0, 8'hA5});
        req[0] = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 8) begin
            tick();
            cyc++;
            got = grant[0];
        end
        chk("stale_first_grant", 32'(got), 32'd1);
        tick();
        set_port(1, 1'b0, 9'h0FF, 8'h00);
        exp_q.push_back('{1, 8'h77});
        req[1] = 1'b1;
        tick();
        tick();
        req[0] = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 8) begin
            tick();
            cyc++;
            got = grant[1];
        end
        chk("stale_port1_grant", 32'(got), 32'd1);
        chk("stale_port1_latency", 32'(cyc), 32'd1);
        req[1] = 1'b0;
        repeat (8) tick();
        chk("stale_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during the ACCESS cycle of a write discards it.
        do_txn(0, 1'b1, 9'h020, 8'h11, 8'h11);
        set_port(0, 1'b1, 9'h020, 8'hEE);
        req[0] = 1'b1;
        tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset  = 1'b1;
        req[0] = 1'b0;
        tick();
        chk("mid_reset_busy", 32'(busy), 32'd0);
        chk("mid_reset_grant", 32'(grant), 32'd0);
        chk("mid_reset_gpio_out", 32'(gpio_out), 32'd0);
        chk("mid_reset_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;
        repeat (6) tick();
        chk("reset_queue_empty", 32'(exp_q.size()), 32'd0);
        do_txn(0, 1'b0, 9'h020, 8'h00, 8'h11);

        // req dropped during ACCESS: the transaction still completes once.
        set_port(0, 1'b0, 9'h0FF, 8'h00);
        exp_q.push_back('{0, 8'h77});
        req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        tick();
        chk("drop_grant", 32'(grant), 32'd1);
        tick();
        chk("drop_grant_width", 32'(grant), 32'd0);
        chk("drop_busy_recover", 32'(busy), 32'd1);
        tick();
        chk("drop_busy_idle", 32'(busy), 32'd0);
        repeat (4) tick();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Slave end of the core bus request/grant protocol.
- Arbitrates up to N_PORTS requesters, round-robin.
- Serves one byte transaction at a time from an internal RAM, or from a small GPIO window when address bit 8 is set.
- Returns a one-cycle grant pulse with read data valid. Sits between the cores and memory/IO at the top level.

Parameters:
- N_PORTS, 2, number of requester ports (1..8)
- RAM_DEPTH, 256, bytes of internal RAM; indexed by address[7:0]
- ADDR_W, 9, bus address width; MSB is the GPIO flag
- DATA_W, 8, bus data width

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- req  input  N_PORTS  grant_request per port
- rw  input  N_PORTS  per port: 0 = read, 1 = write
- addr  input  N_PORTS*ADDR_W  per-port address, port k at [k*9+:9]
- wdata  input  N_PORTS*DATA_W  per-port write data, port k at [k*8+:8]
- grant  output  N_PORTS  grant_given per port, one-hot or zero
- rdata  output  DATA_W  shared read data, valid while grant is high
- gpio_in  input  8  external input byte
- gpio_out  output  8  external output register
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset values: grant=0, rdata=0, gpio_out=0, busy=0, state=IDLE, rr_ptr=0. RAM contents are NOT cleared by reset.
- FSM states and transitions:
  - IDLE: if any req is high, select a winner, latch its addr/rw/wdata and index, then go to ACCESS. Otherwise stay.
  - ACCESS: perform the access using the latched values, then go to GRANT.
    - Write: commit at the end of this cycle.
    - Read: register rdata at the end of this cycle.
  - GRANT: grant[winner]=1 for exactly this cycle; rdata is valid. Set rr_ptr=(winner+1) mod N_PORTS. Go to RECOVER.
  - RECOVER: one dead cycle. The requester drops req on the cycle after its grant, so a stale req is ignored here. Go to IDLE.
- Latency: req sampled in IDLE at cycle 0 -> grant high in cycle 2 -> next arbitration in cycle 4. Back-to-back throughput is one transaction per 4 cycles.
- Arbitration: the winner is the first port with req high, scanning from rr_ptr upward with wrap. With only one requester active, that port always wins.
- Address decode:
  - addr[8]=0: RAM[addr[7:0]].
  - addr[8]=1, addr[0]=0: gpio_out. Readable and writable.
  - addr[8]=1, addr[0]=1: gpio_in. Read only; writes are ignored.
  - addr[7:1] is ignored in the GPIO window; the window aliases.
- Write transactions: rdata is driven with the write data during GRANT, as an echo.
- Inputs change after latch: addr/rw/wdata/req changes after IDLE are ignored. If req drops during ACCESS, the transaction still completes and grant still pulses.
- Simultaneous requests: only the winner is served. Losers keep req high and are served in later rounds. No request is lost.
- Reset mid-transaction: the FSM goes to IDLE next edge and grant drops immediately. A write already committed in ACCESS stays committed; an uncommitted write is discarded.
- rdata holds its last value outside GRANT. Consumers must qualify it with grant.

Decomposition:
- bus_pkg holds:
  - ADDR_W and DATA_W
  - GPIO_FLAG_BIT=8
  - GPIO offsets GPIO_OUT_OFS=0, GPIO_IN_OFS=1
  - typedef enum logic[1:0] {IDLE, ACCESS, GRANT, RECOVER} bus_state_t
  - RW_READ=0, RW_WRITE=1
- One sub-module, rr_arbiter:
  - Parameter N.
  - Inputs req and ptr; outputs a one-hot winner and its index plus a valid flag.
  - Purely combinational; the pointer register lives in bus_responder.

Test Plan:
- Single port 0 writes 0xA5 to address 0x010, then reads 0x010 -> write grant pulses at cycle 2; read grant carries rdata=0xA5, exactly one cycle wide.
- Port 0 writes 0x3C to 0x100 and then reads 0x101 with gpio_in=0x5A -> gpio_out=0x3C after the write's ACCESS cycle; read returns 0x5A. A write of 0xFF to 0x101 leaves gpio_out unchanged.
- Ports 0 and 1 both hold req high continuously -> grants alternate 0,1,0,1, spaced 4 cycles apart, with no double grant.
- Port 1 raises req in the RECOVER cycle of a port-0 grant while port 0 holds a stale req -> port 1 wins next, since rr_ptr=1. Port 0's stale req causes no extra grant.
- reset asserted during ACCESS of a write to 0x020 -> grant never pulses and busy=0 next cycle. gpio_out=0; RAM[0x020] keeps its prior value.
- Port 0 issues a read of 0x0FF, then req drops during ACCESS -> grant[0] still pulses once with RAM[0xFF]; the FSM returns to IDLE at cycle 4.
